riscv_ex_stage: RTL and testbench

Execute stage of the pipelined RV32 core. Three functions:
- Decodes the 2-bit main-controller ALU class plus `{instr[30], funct3}` into a 4-bit ALU operation.
- Performs the 32-bit ALU operation and computes the zero flag.
- Computes the branch target (`pc + imm`).

All results are combinational and also captured in EX/MEM pipeline registers that feed data memory, writeback and next-PC selection.

---
 rtl/riscv_ex_pkg.sv | 32 +++
 rtl/ex_alu_decode.sv | 61 ++++++
 rtl/riscv_ex_stage.sv | 83 ++++++++
 tb/tb_riscv_ex_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/riscv_ex_pkg.sv
// Shared types for the RV32 execute stage: controller ALU classes, ALU operation codes, datapath width.
// Pure declarations; no timing or flow control.
package riscv_ex_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LSST   = 2'b00,
    BRANCH = 2'b01,
    RTYPE  = 2'b10,
    ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_OR      = 4'b0001,
    OP_ADD     = 4'b0010,
    OP_XOR     = 4'b0011,
    OP_SLL     = 4'b0100,
    OP_SRL     = 4'b0101,
    OP_SUB     = 4'b0110,
    OP_SLT     = 4'b0111,
    OP_SRA     = 4'b1000,
    OP_SLTU    = 4'b1001,
    OP_INVALID = 4'b1111
  } alu_operation_e;

  function automatic logic is_base_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ex_alu_decode.sv
// ALU control: (alu_op, {instr[30], funct3}) -> 4-bit operation; combinational, no flow control.
// ALU_EXT_OPS_EN enables shifts/compares/XOR; otherwise only AND/OR/ADD/SUB decode.
module ex_alu_decode
  import riscv_ex_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [3:0] funct73_i,
  output logic [3:0] operation_o
);

`ifdef ALU_EXT_OPS_EN
  localparam bit ExtOps = 1'b1;
`else
  localparam bit ExtOps = 1'b0;
`endif

  logic [3:0] full_op;

  always_comb begin
    full_op = OP_INVALID;
    case (alu_op_e'(alu_op_i))
      LSST:   full_op = OP_ADD;
      BRANCH: full_op = OP_SUB;
      RTYPE: begin
        case (funct73_i)
          4'b0000: full_op = OP_ADD;
          4'b1000: full_op = OP_SUB;
          4'b0001: full_op = OP_SLL;
          4'b0010: full_op = OP_SLT;
          4'b0011: full_op = OP_SLTU;
          4'b0100: full_op = OP_XOR;
          4'b0101: full_op = OP_SRL;
          4'b1101: full_op = OP_SRA;
          4'b0110: full_op = OP_OR;
          4'b0111: full_op = OP_AND;
          default: full_op = OP_INVALID;
        endcase
      end
      ITYPE: begin
        // instr[30] is part of the immediate for I-type, except on the shift-right encoding
        case (funct73_i[2:0])
          3'b000:  full_op = OP_ADD;
          3'b001:  full_op = OP_SLL;
          3'b010:  full_op = OP_SLT;
          3'b011:  full_op = OP_SLTU;
          3'b100:  full_op = OP_XOR;
          3'b101:  full_op = funct73_i[3] ? OP_SRA : OP_SRL;
          3'b110:  full_op = OP_OR;
          default: full_op = OP_AND;
        endcase
      end
      default: full_op = OP_INVALID;
    endcase
  end

  always_comb begin
    operation_o = full_op;
    if (!ExtOps && !is_base_op(full_op)) operation_o = OP_INVALID;
  end

endmodule

// File: rtl/riscv_ex_stage.sv
// RV32 execute stage: ALU decode, ALU + zero flag, branch adder; combinational results plus EX/MEM regs (1 cycle, en holds).
// No handshake: one operation per cycle. Extended ALU ops gated by ALU_EXT_OPS_EN in ex_alu_decode.
module riscv_ex_stage
  import riscv_ex_pkg::*;
#(
  parameter int XLEN = riscv_ex_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      alu_op,
  input  logic [3:0]      funct73,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic [3:0]      operation,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] alu_result_q,
  output logic            zero_q,
  output logic [XLEN-1:0] br_target_q
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] alu_result_d;
  logic            zero_d;
  logic [XLEN-1:0] br_target_d;

  ex_alu_decode u_decode (
    .alu_op_i    (alu_op),
    .funct73_i   (funct73),
    .operation_o (operation)
  );

  assign shamt = operand2[4:0];

  always_comb begin
    alu_result = '0;
    case (operation)
      OP_AND:  alu_result = operand1 & operand2;
      OP_OR:   alu_result = operand1 | operand2;
      OP_ADD:  alu_result = operand1 + operand2;
      OP_SUB:  alu_result = operand1 - operand2;
      OP_XOR:  alu_result = operand1 ^ operand2;
      OP_SLL:  alu_result = operand1 << shamt;
      OP_SRL:  alu_result = operand1 >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(operand1) >>> shamt);
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, operand1 < operand2};
      default: alu_result = '0;
    endcase
  end

  // Zero is taken from the final result so INVALID (result 0) also reads as zero
  assign zero      = (alu_result == '0);
  assign br_target = pc + imm;

  always_comb begin
    alu_result_d = alu_result_q;
    zero_d       = zero_q;
    br_target_d  = br_target_q;
    if (en) begin
      alu_result_d = alu_result;
      zero_d       = zero;
      br_target_d  = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      br_target_q  <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      br_target_q  <= br_target_d;
    end
  end

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Directed-vector bench for riscv_ex_stage; expectations follow ALU_EXT_OPS_EN.
module tb_riscv_ex_stage;

`ifdef ALU_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  alu_op;
  logic [3:0]  funct73;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [3:0]  operation;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] alu_result_q;
  logic        zero_q;
  logic [31:0] br_target_q;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_ex_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .alu_op       (alu_op),
    .funct73      (funct73),
    .operand1     (operand1),
    .operand2     (operand2),
    .pc           (pc),
    .imm          (imm),
    .operation    (operation),
    .alu_result   (alu_result),
    .zero         (zero),
    .alu_result_q (alu_result_q),
    .zero_q       (zero_q),
    .br_target_q  (br_target_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, check combinational outputs, then the captured copies after one edge.
  task automatic run_vec(input string tag, input logic [1:0] aop, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_op, input logic [31:0] exp_res);
    alu_op = aop; funct73 = f; operand1 = a; operand2 = b; en = 1'b1;
    #1;
    chk({tag, ".op"},   {28'd0, operation}, {28'd0, exp_op});
    chk({tag, ".res"},  alu_result, exp_res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    step();
    chk({tag, ".res_q"},  alu_result_q, exp_res);
    chk({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, (exp_res == 32'd0)});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; alu_op = 2'b00; funct73 = 4'b0000;
    operand1 = 32'd3; operand2 = 32'd4; pc = 32'h100; imm = 32'h10;

    // Reset held with nonzero inputs and a running clock
    repeat (3) step();
    chk("rst.res_q",  alu_result_q, 32'd0);
    chk("rst.zero_q", {31'd0, zero_q}, 32'd0);
    chk("rst.br_q",   br_target_q, 32'd0);
    chk("rst.comb",   alu_result, 32'd7);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first.res_q", alu_result_q, 32'd7);
    chk("first.br_q",  br_target_q, 32'h110);

    run_vec("sub_eq",  2'b10, 4'b1000, 32'd5, 32'd5, 4'b0110, 32'd0);
    run_vec("sra",     2'b10, 4'b1101, 32'h8000_0000, 32'd4,
            EXT ? 4'b1000 : 4'hF, EXT ? 32'hF800_0000 : 32'd0);
    run_vec("srl",     2'b10, 4'b0101, 32'h8000_0000, 32'd4,
            EXT ? 4'b0101 : 4'hF, EXT ? 32'h0800_0000 : 32'd0);
    run_vec("slt",     2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1,
            EXT ? 4'b0111 : 4'hF, EXT ? 32'd1 : 32'd0);
    run_vec("sltu",    2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1,
            EXT ? 4'b1001 : 4'hF, 32'd0);
    run_vec("ld_wrap", 2'b00, 4'b1111, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0);
    run_vec("xor",     2'b10, 4'b0100, 32'h0000_0F0F, 32'h0000_00FF,
            EXT ? 4'b0011 : 4'hF, EXT ? 32'h0000_0FF0 : 32'd0);
    run_vec("branch",  2'b01, 4'b0000, 32'd10, 32'd3, 4'b0110, 32'd7);
    run_vec("or",      2'b10, 4'b0110, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF);
    run_vec("and",     2'b10, 4'b0111, 32'h0000_00F0, 32'h0000_003C, 4'b0000, 32'h0000_0030);
    run_vec("addi",    2'b11, 4'b1000, 32'd1, 32'd2, 4'b0010, 32'd3);
    run_vec("srai",    2'b11, 4'b1101, 32'h8000_0000, 32'h0000_0021,
            EXT ? 4'b1000 : 4'hF, EXT ? 32'hC000_0000 : 32'd0);
    run_vec("slli",    2'b11, 4'b0001, 32'd1, 32'd31,
            EXT ? 4'b0100 : 4'hF, EXT ? 32'h8000_0000 : 32'd0);
    run_vec("r_inval", 2'b10, 4'b1001, 32'd1, 32'd1, 4'hF, 32'd0);
    run_vec("ori",     2'b11, 4'b0110, 32'h5, 32'hA, 4'b0001, 32'hF);
    run_vec("add_ovf", 2'b10, 4'b0000, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000);
    run_vec("sltiu",   2'b11, 4'b0011, 32'd1, 32'hFFFF_FFFF,
            EXT ? 4'b1001 : 4'hF, EXT ? 32'd1 : 32'd0);

    // Branch target capture, then hold with en low
    alu_op = 2'b00; operand1 = 32'd9; operand2 = 32'd1;
    pc = 32'h0000_0100; imm = 32'hFFFF_FFF8; en = 1'b1;
    step();
    chk("br.target_q", br_target_q, 32'h0000_00F8);
    chk("br.res_q",    alu_result_q, 32'd10);
    en = 1'b0; pc = 32'h0000_0200; imm = 32'd4; operand1 = 32'd0; operand2 = 32'd0;
    step();
    chk("hold.br_q",   br_target_q, 32'h0000_00F8);
    chk("hold.res_q",  alu_result_q, 32'd10);
    chk("hold.zero_q", {31'd0, zero_q}, 32'd0);
    chk("hold.comb0",  {31'd0, zero}, 32'd1);

    en = 1'b1; pc = 32'hFFFF_FFFC; imm = 32'd8;
    step();
    chk("br.wrap", br_target_q, 32'd4);

    // Asynchronous reset between clock edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.br_q",  br_target_q, 32'd0);
    chk("arst.zero_q", {31'd0, zero_q}, 32'd0);
    #2;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
